demux_scan_n: RTL and testbench

- Parametrised, registered 1-to-N demultiplexer for row/column select in the display driver path.
- Manual mode: steers the enable to the output picked by an external select.
- Scan mode: cycles through all N outputs on its own, holding each one for a programmable number of cycles, and pulses once per full frame.
- Keeps the team's select-to-output mapping: select value k drives out[N_OUT-1-k], so select 0 drives the MSB output.

---
 rtl/display_pkg.sv | 17 +
 rtl/scan_counter.sv | 46 ++++
 rtl/demux_scan_n.sv | 100 ++++++++++
 tb/tb_demux_scan_n.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and helpers for the display driver select path.
// Holds the default output count, dwell length and the reversed one-hot encoder.
package display_pkg;

   localparam int DEFAULT_N_OUT = 4;
   localparam int DEFAULT_DWELL = 4;
   localparam int MAX_OUT       = 32;

   // Select k lights output n-1-k. An index past n-1 makes the unsigned shift
   // amount wrap to a huge value, so the result is all-zero.
   function automatic logic [MAX_OUT-1:0] onehot_rev(input int unsigned idx, input int unsigned n);
      logic [MAX_OUT-1:0] one;
      one = {{(MAX_OUT-1){1'b0}}, 1'b1};
      return one << (n - 1 - idx);
   endfunction

endpackage

// File: rtl/scan_counter.sv
// Dwell counter with a wrapping channel index for the auto-scan demux.
// advance/wrap are combinational flags for the edge on which the index moves.
module scan_counter
   import display_pkg::*;
#(
   parameter int N_OUT = DEFAULT_N_OUT,
   parameter int DWELL = DEFAULT_DWELL
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     run,
   input  logic                     clear,
   output logic [$clog2(N_OUT)-1:0] idx,
   output logic                     advance,
   output logic                     wrap
);

   localparam int IDX_W = $clog2(N_OUT);
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OUT - 1);

   logic [CNT_W-1:0] cnt;

   assign advance = run && !clear && (cnt == CNT_LAST);
   assign wrap    = advance && (idx == IDX_LAST);

   // clear wins over run so leaving scan mode always restarts from channel 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (clear) begin
         cnt <= '0;
         idx <= '0;
      end else if (run) begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux_scan_n.sv
// Registered 1-to-N demux with manual select and auto-scan modes (select k drives out[N_OUT-1-k]).
// Define DEMUX_SCAN_BLANK_EN to insert one blank cycle on every scan index change.
module demux_scan_n
   import display_pkg::*;
#(
   parameter int N_OUT = DEFAULT_N_OUT,
   parameter int SEL_W = $clog2(N_OUT),
   parameter int DWELL = DEFAULT_DWELL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             input_e,
   input  logic             input_mode,
   input  logic [SEL_W-1:0] input_sel,
   output logic [N_OUT-1:0] out,
   output logic [SEL_W-1:0] cur_sel,
   output logic             frame_done
);

`ifdef DEMUX_SCAN_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   logic [SEL_W-1:0] scan_idx;
   logic [SEL_W-1:0] idx;
   logic [31:0]      idx_wide;
   logic [N_OUT-1:0] out_next;
   logic             frame_next;
   logic             advance;
   logic             wrap;
   logic             scan_run;
   logic             scan_clear;
   logic             blank_pending;
   logic             wrapped;

   // The counter stalls during a blank cycle so every channel still gets a full dwell.
   assign scan_run   = input_mode && input_e && !blank_pending;
   assign scan_clear = !input_mode;

   scan_counter #(
      .N_OUT (N_OUT),
      .DWELL (DWELL)
   ) u_scan (
      .clk     (clk),
      .rst     (rst),
      .run     (scan_run),
      .clear   (scan_clear),
      .idx     (scan_idx),
      .advance (advance),
      .wrap    (wrap)
   );

   always_comb begin
      idx        = input_mode ? scan_idx : input_sel;
      idx_wide   = 32'(idx);
      out_next   = '0;
      if (input_e && !(input_mode && blank_pending) && (idx_wide < 32'(N_OUT)))
         out_next = N_OUT'(onehot_rev(idx_wide, N_OUT));
      frame_next = input_mode && input_e && !blank_pending && wrapped && (scan_idx == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out        <= '0;
         cur_sel    <= '0;
         frame_done <= 1'b0;
      end else begin
         out        <= out_next;
         cur_sel    <= idx;
         frame_done <= frame_next;
      end
   end

   // wrapped remembers a wrap until channel 0 is actually shown, so a pause
   // right after the wrap still yields exactly one frame_done on resume.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wrapped <= 1'b0;
      else if (!input_mode)
         wrapped <= 1'b0;
      else if (wrap)
         wrapped <= 1'b1;
      else if (frame_next)
         wrapped <= 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         blank_pending <= 1'b0;
      else if (!input_mode)
         blank_pending <= 1'b0;
      else if (advance && BLANK_EN)
         blank_pending <= 1'b1;
      else if (input_e)
         blank_pending <= 1'b0;
   end

endmodule

// File: tb/tb_demux_scan_n.sv
// Self-checking bench for demux_scan_n: a 4-output/DWELL=3 instance and a 5-output/DWELL=1 instance
// compared against a frame-position reference model; honours DEMUX_SCAN_BLANK_EN.
module tb_demux_scan_n;

   localparam int N_A = 4;
   localparam int D_A = 3;
   localparam int N_B = 5;
   localparam int D_B = 1;
`ifdef DEMUX_SCAN_BLANK_EN
   localparam int BLK = 1;
`else
   localparam int BLK = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a_e = 1'b0, a_mode = 1'b0;
   logic [1:0] a_sel = '0;
   logic [3:0] a_out;
   logic [1:0] a_cur;
   logic       a_fd;
   logic       b_e = 1'b0, b_mode = 1'b0;
   logic [2:0] b_sel = '0;
   logic [4:0] b_out;
   logic [2:0] b_cur;
   logic       b_fd;

   int n_checks = 0;
   int n_fail   = 0;
   int pos_a = 0, pos_b = 0;
   bit wr_a = 0, wr_b = 0;
   int ea_out, ea_cur, eb_out, eb_cur;
   bit ea_fd, eb_fd;

   always #5 clk = ~clk;

   demux_scan_n #(.N_OUT(N_A), .DWELL(D_A)) dut_a (
      .clk(clk), .rst(rst), .input_e(a_e), .input_mode(a_mode), .input_sel(a_sel),
      .out(a_out), .cur_sel(a_cur), .frame_done(a_fd));

   demux_scan_n #(.N_OUT(N_B), .DWELL(D_B)) dut_b (
      .clk(clk), .rst(rst), .input_e(b_e), .input_mode(b_mode), .input_sel(b_sel),
      .out(b_out), .cur_sel(b_cur), .frame_done(b_fd));

   // A scan frame is n*(d+BLK) active cycles; pos is the place within it.
   task automatic model(input int n, input int d, input logic mode, input logic e, input int sel,
                        inout int pos, inout bit wr, output int eo, output int ec, output bit ef);
      int per, c, ph;
      bit blank;
      per = d + BLK;
      eo = 0;
      ef = 0;
      if (!mode) begin
         ec = sel;
         if (e && sel < n) eo = 1 << (n - 1 - sel);
         pos = 0;
         wr  = 0;
      end else begin
         c     = pos / per;
         ph    = pos % per;
         blank = (ph >= d);
         ec    = blank ? (c + 1) % n : c;
         if (e) begin
            if (!blank) eo = 1 << (n - 1 - c);
            ef  = (pos == 0) && wr;
            pos = pos + 1;
            if (pos == n * per) begin
               pos = 0;
               wr  = 1;
            end
         end
      end
   endtask

   task automatic tick();
      model(N_A, D_A, a_mode, a_e, int'(a_sel), pos_a, wr_a, ea_out, ea_cur, ea_fd);
      model(N_B, D_B, b_mode, b_e, int'(b_sel), pos_b, wr_b, eb_out, eb_cur, eb_fd);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      n_checks++;
      if ({a_out, a_cur, a_fd, b_out, b_cur, b_fd} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_state: got a=%b/%0d/%b b=%b/%0d/%b, want all zero",
                  a_out, a_cur, a_fd, b_out, b_cur, b_fd);
      end
      rst = 1'b0;
   endtask

   task automatic test_manual();
      a_mode = 1'b0;
      a_e    = 1'b1;
      for (int k = 0; k < 4; k++) begin
         a_sel = 2'(k);
         tick();
         n_checks++;
         if ({a_out, a_cur, a_fd} !== {4'(8 >> k), 2'(k), 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL manual_sel%0d: got out=%b cur=%0d fd=%b, want out=%b cur=%0d fd=0",
                     k, a_out, a_cur, a_fd, 4'(8 >> k), k);
         end
      end
      a_e = 1'b0;
      tick();
      n_checks++;
      if (a_out !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL manual_e_low: got out=%b, want 0000", a_out);
      end
   endtask

   task automatic test_scan_sequence();
      int fd_count;
      fd_count = 0;
      a_mode = 1'b0;
      tick();
      a_mode = 1'b1;
      a_e    = 1'b1;
      for (int i = 0; i < 24; i++) begin
         tick();
         fd_count += int'(a_fd);
         n_checks++;
         if ({a_out, a_cur, a_fd} !== {4'(ea_out), 2'(ea_cur), ea_fd}) begin
            n_fail++;
            $display("[TB] FAIL scan_seq cyc=%0d: got out=%b cur=%0d fd=%b, want out=%b cur=%0d fd=%b",
                     i, a_out, a_cur, a_fd, 4'(ea_out), ea_cur, ea_fd);
         end
         n_checks++;
         if ($countones(a_out) > 1) begin
            n_fail++;
            $display("[TB] FAIL scan_onehot cyc=%0d: got out=%b, want at most one bit set", i, a_out);
         end
      end
      n_checks++;
      if (fd_count != 1) begin
         n_fail++;
         $display("[TB] FAIL scan_fd_count: got %0d pulses, want 1", fd_count);
      end
   endtask

   task automatic test_pause_resume();
      a_mode = 1'b0;
      tick();
      a_mode = 1'b1;
      for (int i = 0; i < 76; i++) begin
         if (i < 16)      a_e = !(i >= 5 && i < 10);
         else             a_e = ($urandom_range(0, 3) != 0);
         tick();
         n_checks++;
         if ({a_out, a_cur, a_fd} !== {4'(ea_out), 2'(ea_cur), ea_fd}) begin
            n_fail++;
            $display("[TB] FAIL pause_resume cyc=%0d e=%b: got out=%b cur=%0d fd=%b, want out=%b cur=%0d fd=%b",
                     i, a_e, a_out, a_cur, a_fd, 4'(ea_out), ea_cur, ea_fd);
         end
      end
   endtask

   task automatic test_mode_switch();
      a_e    = 1'b1;
      a_mode = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      a_mode = 1'b0;
      a_sel  = 2'd3;
      tick();
      n_checks++;
      if ({a_out, a_cur, a_fd} !== {4'b0001, 2'd3, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL to_manual: got out=%b cur=%0d fd=%b, want out=0001 cur=3 fd=0", a_out, a_cur, a_fd);
      end
      a_mode = 1'b1;
      tick();
      n_checks++;
      if ({a_out, a_cur, a_fd} !== {4'b1000, 2'd0, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL to_scan: got out=%b cur=%0d fd=%b, want out=1000 cur=0 fd=0", a_out, a_cur, a_fd);
      end
   endtask

   task automatic test_reset_mid_scan();
      a_mode = 1'b1;
      a_e    = 1'b1;
      b_mode = 1'b1;
      b_e    = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({a_out, a_cur, a_fd, b_out, b_cur, b_fd} !== '0) begin
         n_fail++;
         $display("[TB] FAIL async_reset: got a=%b/%0d/%b b=%b/%0d/%b, want all zero",
                  a_out, a_cur, a_fd, b_out, b_cur, b_fd);
      end
      @(posedge clk);
      #1;
      pos_a = 0; wr_a = 0;
      pos_b = 0; wr_b = 0;
      rst = 1'b0;
      tick();
      n_checks++;
      if ({a_out, a_cur, a_fd} !== {4'b1000, 2'd0, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL after_reset: got out=%b cur=%0d fd=%b, want out=1000 cur=0 fd=0", a_out, a_cur, a_fd);
      end
   endtask

   task automatic test_npow2();
      b_mode = 1'b0;
      b_e    = 1'b1;
      tick();
      b_mode = 1'b1;
      for (int i = 0; i < 14; i++) begin
         tick();
         n_checks++;
         if ({b_out, b_cur, b_fd} !== {5'(eb_out), 3'(eb_cur), eb_fd}) begin
            n_fail++;
            $display("[TB] FAIL npow2_scan cyc=%0d: got out=%b cur=%0d fd=%b, want out=%b cur=%0d fd=%b",
                     i, b_out, b_cur, b_fd, 5'(eb_out), eb_cur, eb_fd);
         end
      end
      b_mode = 1'b0;
      for (int s = 4; s < 8; s++) begin
         b_sel = 3'(s);
         tick();
         n_checks++;
         if ({b_out, b_cur, b_fd} !== {5'(s == 4 ? 1 : 0), 3'(s), 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL npow2_sel%0d: got out=%b cur=%0d fd=%b, want out=%b cur=%0d fd=0",
                     s, b_out, b_cur, b_fd, 5'(s == 4 ? 1 : 0), s);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) a_mode = ~a_mode;
         if ($urandom_range(0, 15) == 0) b_mode = ~b_mode;
         a_e   = ($urandom_range(0, 3) != 0);
         b_e   = ($urandom_range(0, 3) != 0);
         a_sel = 2'($urandom);
         b_sel = 3'($urandom);
         tick();
         n_checks++;
         if ({a_out, a_cur, a_fd} !== {4'(ea_out), 2'(ea_cur), ea_fd}) begin
            n_fail++;
            $display("[TB] FAIL random_a cyc=%0d: got out=%b cur=%0d fd=%b, want out=%b cur=%0d fd=%b",
                     i, a_out, a_cur, a_fd, 4'(ea_out), ea_cur, ea_fd);
         end
         n_checks++;
         if ({b_out, b_cur, b_fd} !== {5'(eb_out), 3'(eb_cur), eb_fd}) begin
            n_fail++;
            $display("[TB] FAIL random_b cyc=%0d: got out=%b cur=%0d fd=%b, want out=%b cur=%0d fd=%b",
                     i, b_out, b_cur, b_fd, 5'(eb_out), eb_cur, eb_fd);
         end
         n_checks++;
         if ($countones(a_out) > 1 || $countones(b_out) > 1) begin
            n_fail++;
            $display("[TB] FAIL random_onehot cyc=%0d: got a=%b b=%b, want at most one bit set each", i, a_out, b_out);
         end
      end
   endtask

   initial begin
      test_reset();
      test_manual();
      test_scan_sequence();
      test_pause_resume();
      test_mode_switch();
      test_npow2();
      test_reset_mid_scan();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
